bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential double-dabble converter that turns an unsigned binary word into packed BCD digits. It sits directly downstream of the 4x4 carry-save array multiplier: the 8-bit product `p` drives `bin`, and the BCD result feeds the display/digit logic. One conversion runs over BIN_W shift cycles, using a start/busy/done handshake.

## Interface
- `BIN_W`, default 8: width of the binary input. Must satisfy 10^DIGITS > 2^BIN_W − 1.
- `DIGITS`, default 3: number of BCD output digits, 4 bits each.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: conversion request. Sampled only in IDLE.
- `bin` in BIN_W: unsigned operand. Captured on the accepting edge; later changes are ignored.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse marking that `bcd` holds a new result.
- `bcd` out 4*DIGITS: packed digits, [3:0] is the ones digit. Holds the last result until the next `done`.
- `blank` out DIGITS: leading-zero mask. Present only with `BIN2BCD_BLANK_EN`.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `start`=1 loads the shift register: BCD part = 0, binary part = `bin`.
  - Clears the iteration counter and moves to SHIFT.
  - `start`=0 stays in IDLE.
- **SHIFT:** each cycle does one iteration.
  - Every BCD nibble ≥ 5 gets +3, all nibbles in parallel.
  - Then the whole {bcd, bin} register shifts left by 1.
  - The counter increments.
  - After iteration BIN_W, the final BCD value is written to the `bcd` output register, `done` is set, and the state moves to DONE.
- **DONE:** lasts exactly one cycle, then returns to IDLE.
- **`start` while busy:** ignored in SHIFT and DONE. There is no queueing and no error flag.
- **Arithmetic:**
  - Adjust rule per nibble is n + 3 when n ≥ 5, else n. The add is 4-bit and cannot overflow, since n ≤ 9 before adjust.
  - Shift register width is 4*DIGITS + BIN_W.
  - Counter width is clog2(BIN_W+1).
- **Bounds:** `bin`=0 gives all-zero digits. `bin`=2^BIN_W−1 gives the correct maximum value (255 → 2,5,5 at default).
- **Reset mid-conversion:** aborts immediately.
  - State goes to IDLE.
  - No `done` pulse is issued.
  - `bcd` is cleared to 0.

## Timing
- **Reset values:** `busy`=0, `done`=0, `bcd`=0. With `BIN2BCD_BLANK_EN`, `blank` = all upper digits set and bit 0 = 0.
- **Start at edge E0:** `start`=1 in IDLE is sampled at E0.
  - `busy`=1 from E0.
  - Iterations run at edges E1..E_BIN_W.
- **Result at edge E_BIN_W:** `bcd` updates and `done`=1 for the following cycle. `busy` is still high during that cycle.
- **Edge E_BIN_W+1:** `done`=0 and `busy`=0.
- **Latency and throughput:** result latency is BIN_W cycles from the accepting edge. Minimum start-to-start spacing is BIN_W+2 cycles (10 at default).
- **Path:** no combinational path from inputs to outputs; all outputs are registered.

## Configuration
- **Macro:** `BIN2BCD_BLANK_EN`.
- **Defined:**
  - The `blank` port exists and is registered together with `bcd`.
  - blank[i] = 1 iff digit i and every higher digit are zero, for i ≥ 1.
  - blank[0] is always 0.
- **Undefined:** the `blank` port and its logic are absent. Everything else is identical.

## Structure
- **Package `bin2bcd_pkg`:**
  - State enum (IDLE, SHIFT, DONE).
  - `BCD_DIGIT_W` = 4.
  - Adjust threshold `BCD_ADJ_TH` = 5 and add constant `BCD_ADJ_ADD` = 3.
  - Default `BIN_W` and `DIGITS` constants.
- **Sub-module `bcd_digit_adj`:** combinational, 4-bit in, 4-bit out, applies the add-3 rule. Instantiated DIGITS times in a generate loop.

## Test plan
- **Zero:** reset, then `bin`=0 with `start` pulse → `done` exactly 8 cycles after the accepting edge, `bcd`=0x000, `blank`=3'b110.
- **Maximum:** `bin`=255 → `bcd`=0x255, `blank`=3'b000. `busy` drops one cycle after `done`.
- **Multiplier max:** `bin`=225 (15×15, driven from the multiplier product) → `bcd`=0x225. `bin` changed to 0 during SHIFT → result unchanged.
- **Start while busy:** `start` held high for 20 cycles with `bin`=7 → first `bcd`=0x007 (`blank`=3'b110). Second acceptance occurs on the edge after DONE, i.e. 10 cycles after the first.
- **Reset mid-conversion:** `bin`=99, `rst` asserted after 4 iterations → no `done`, `bcd`=0, `busy`=0. The next `start` with `bin`=100 → `bcd`=0x100, `blank`=3'b000.
- **Exhaustive sweep:** all 256 inputs back-to-back → every `bcd` matches the decimal reference, with exactly one `done` per accepted start.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_ADJ_TH  = 5;
    localparam int BCD_ADJ_ADD = 3;

    localparam int BIN_W_DEF  = 8;
    localparam int DIGITS_DEF = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble of the double-dabble add-3 correction.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nib,
    output logic [BCD_DIGIT_W-1:0] adj
);

    localparam logic [BCD_DIGIT_W-1:0] TH  = BCD_DIGIT_W'(BCD_ADJ_TH);
    localparam logic [BCD_DIGIT_W-1:0] ADD = BCD_DIGIT_W'(BCD_ADJ_ADD);

    always_comb begin
        adj = nib;
        if (nib >= TH) begin
            adj = nib + ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter, one shift per cycle.
// Optional leading-zero mask output enabled by BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BIN_W-1:0]                bin,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]               blank
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t state;
    state_t state_nx;

    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_sh;
    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] bcd_nx;
    logic [CNT_W-1:0] cnt;
    logic             last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib (sr[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .adj (adj_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    assign sr_sh  = {adj_bcd, sr[BIN_W-1:0]} << 1;
    assign bcd_nx = sr_sh[SR_W-1 -: BCD_W];
    assign last   = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zero_above;

    // A digit blanks only if it and every more significant digit are zero.
    always_comb begin
        blank_nx   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above &
                          (bcd_nx[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
            blank_nx[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank <= ~DIGITS'(1);
        end else if (state == SHIFT && last) begin
            blank <= blank_nx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= {{BCD_W{1'b0}}, bin};
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_sh;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        bcd <= bcd_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  acc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [BIN_W-1:0]    bin = '0;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_acc = 0;
    bit   prev_done = 1'b0;
    exp_t exp_q[$];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int v, input int acc);
        exp_t e;
        e.bcd   = ref_bcd(v);
        e.blank = ref_blank(v);
        e.acc   = acc;
        exp_q.push_back(e);
        n_acc++;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(!busy, "idle_wait", int'(busy), 0);
    endtask

    task automatic conv(input int v);
        wait_idle();
        push_exp(v, cyc + 1);
        bin   = BIN_W'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(busy, "busy_after_start", int'(busy), 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_done) begin
                check(!busy && !done, "busy_drop",
                      int'({busy, done}), 0);
            end
            if (done) begin
                n_done++;
                check(busy, "busy_during_done", int'(busy), 1);
                check(exp_q.size() != 0, "done_expected",
                      exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(bcd == e.bcd, "bcd", int'(bcd), int'(e.bcd));
`ifdef BIN2BCD_BLANK_EN
                    check(blank == e.blank, "blank",
                          int'(blank), int'(e.blank));
`endif
                    check(cyc - e.acc == BIN_W, "latency",
                          cyc - e.acc, BIN_W);
                end
            end
        end
        prev_done = done && !rst;
    end

    initial begin
        int d0;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!busy, "reset_busy", int'(busy), 0);
        check(!done, "reset_done", int'(done), 0);
        check(bcd == '0, "reset_bcd", int'(bcd), 0);
`ifdef BIN2BCD_BLANK_EN
        check(blank == 3'b110, "reset_blank", int'(blank), 6);
`endif
        rst = 1'b0;

        conv(0);
        conv(255);
        conv(225);
        repeat (3) @(negedge clk);
        bin = '0;

        wait_idle();
        push_exp(7, cyc + 1);
        push_exp(7, cyc + 1 + BIN_W + 2);
        bin   = 8'd7;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;

        wait_idle();
        d0    = n_done;
        bin   = 8'd99;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(bcd == '0, "abort_bcd", int'(bcd), 0);
        check(!busy, "abort_busy", int'(busy), 0);
        check(!done, "abort_done", int'(done), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check(n_done == d0, "abort_no_done", n_done, d0);

        conv(100);

        for (int v = 0; v < (1 << BIN_W); v++) begin
            conv(v);
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            conv(int'($urandom_range(0, (1 << BIN_W) - 1)));
        end

        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        check(n_done == n_acc, "done_count", n_done, n_acc);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
